// File: rtl/deint_pkg.sv
// Shared types and sizing helpers for the block deinterleaver.
package deint_pkg;

   localparam int ROWS_DEF = 4;
   localparam int COLS_DEF = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      RUN  = 2'd2
   } state_e;

   // Width of an index that can address 0..n-1; never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/deint_addr_gen.sv
// Symbol index counter with ping-pong bank select. Produces the scatter
// write position that undoes the interleaver and the sequential read position.
module deint_addr_gen
   import deint_pkg::*;
#(
   parameter int ROWS = ROWS_DEF,
   parameter int COLS = COLS_DEF,
   localparam int N  = ROWS * COLS,
   localparam int IW = idx_width(N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          adv_i,
   input  logic          restart_i,
   output logic [IW-1:0] k_o,
   output logic [IW-1:0] idx_o,
   output logic [IW-1:0] wpos_o,
   output logic [IW-1:0] rpos_o,
   output logic          bank_o,
   output logic          wrap_o
);

   logic [IW-1:0] k_q, k_d;
   logic          bank_q, bank_d;

   // Effective index of the current symbol, its positions and the next count.
   // A restart forces this symbol to index 0 of a fresh block.
   always_comb begin
      idx_o  = restart_i ? '0 : k_q;
      wrap_o = (idx_o == IW'(N - 1));
      wpos_o = IW'((int'(idx_o) % ROWS) * COLS + int'(idx_o) / ROWS);
      rpos_o = idx_o;
      k_d    = k_q;
      bank_d = bank_q;
      if (adv_i) begin
         k_d = wrap_o ? '0 : idx_o + IW'(1);
         if (wrap_o) begin
            bank_d = ~bank_q;
         end
      end
   end

   // Counter and bank-select registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         k_q    <= '0;
         bank_q <= 1'b0;
      end else begin
         k_q    <= k_d;
         bank_q <= bank_d;
      end
   end

   assign k_o    = k_q;
   assign bank_o = bank_q;

endmodule

// File: rtl/deinterleaver.sv
// Block deinterleaver paired with an R x C row-in/column-out interleaver.
// Two N-bit banks ping-pong: one is scatter-written while the other is read out.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | unlocked; waiting for valid_i with sync_i to start block index 0
// FILL  | first block after lock/resync being written; nothing emitted
// RUN   | each accepted symbol writes one bank and emits one bit from the other
module deinterleaver
   import deint_pkg::*;
#(
   parameter int ROWS = ROWS_DEF,
   parameter int COLS = COLS_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic data_i,
   input  logic valid_i,
   input  logic sync_i,
   output logic data_o,
   output logic valid_o,
   output logic sync_o,
   output logic sync_err_o
);

   localparam int N  = ROWS * COLS;
   localparam int IW = idx_width(N);

   state_e           state_q, state_d;
   logic [1:0][N-1:0] bank_q, bank_d;
   logic             data_q, data_d;
   logic             valid_q, valid_d;
   logic             sync_q, sync_d;
   logic             err_q, err_d;

   logic             acc;
   logic             misplaced;
   logic             restart;
   logic             emit;
   logic [IW-1:0]    k_cur;
   logic [IW-1:0]    idx;
   logic [IW-1:0]    wpos;
   logic [IW-1:0]    rpos;
   logic             wbank;
   logic             wrap;

   // Accept/resync qualification; a sync away from index 0 restarts the block.
   always_comb begin
      misplaced = valid_i && sync_i && (state_q != IDLE) && (k_cur != '0);
      acc       = valid_i && ((state_q != IDLE) || sync_i);
      restart   = (state_q == IDLE) || misplaced;
   end

   deint_addr_gen #(
      .ROWS(ROWS),
      .COLS(COLS)
   ) u_addr_gen (
      .clk       (clk),
      .rst       (rst),
      .adv_i     (acc),
      .restart_i (restart),
      .k_o       (k_cur),
      .idx_o     (idx),
      .wpos_o    (wpos),
      .rpos_o    (rpos),
      .bank_o    (wbank),
      .wrap_o    (wrap)
   );

   // Next state, bank write and output bit selection.
   always_comb begin
      state_d = state_q;
      bank_d  = bank_q;
      data_d  = data_q;
      valid_d = 1'b0;
      sync_d  = 1'b0;
      err_d   = misplaced;
      emit    = acc && (state_q == RUN) && !misplaced;

      if (acc) begin
         bank_d[wbank][wpos] = data_i;
      end

      if (emit) begin
         valid_d = 1'b1;
         sync_d  = (idx == '0);
         data_d  = bank_q[~wbank][rpos];
      end

      case (state_q)
         IDLE: begin
            if (acc) begin
               state_d = wrap ? RUN : FILL;
            end
         end
         FILL: begin
            if (acc && wrap) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (misplaced) begin
               state_d = FILL;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM, bank storage and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         bank_q  <= '0;
         data_q  <= 1'b0;
         valid_q <= 1'b0;
         sync_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         bank_q  <= bank_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         sync_q  <= sync_d;
         err_q   <= err_d;
      end
   end

   assign data_o     = data_q;
   assign valid_o    = valid_q;
   assign sync_o     = sync_q;
   assign sync_err_o = err_q;

endmodule

// File: tb/tb_deinterleaver.sv
// Scoreboard bench: source blocks are interleaved (row-in, column-out) here,
// and the expected deinterleaved bit is queued when the symbol is driven.
module tb_deinterleaver;

   localparam int R = 4;
   localparam int C = 4;
   localparam int N = R * C;

   typedef struct packed {
      logic d;
      logic s;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   logic data_i, valid_i, sync_i;
   logic data_o, valid_o, sync_o, sync_err_o;

   exp_t         q[$];
   exp_t         mon_e;
   int           n_checks = 0;
   int           n_errors = 0;
   int           err_seen = 0;
   int           vo_low_cnt = 0;
   logic [N-1:0] prev_src;
   bit           have_prev;

   deinterleaver #(.ROWS(R), .COLS(C)) dut (
      .clk        (clk),
      .rst        (rst),
      .data_i     (data_i),
      .valid_i    (valid_i),
      .sync_i     (sync_i),
      .data_o     (data_o),
      .valid_o    (valid_o),
      .sync_o     (sync_o),
      .sync_err_o (sync_err_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Interleaver reference: source bit r*C+c goes out at stream position c*R+r.
   function automatic logic il_bit(input logic [N-1:0] src, input int k);
      int r = k % R;
      int c = k / R;
      return src[r*C + c];
   endfunction

   // All drive tasks are entered at a negedge and return at a negedge.
   task automatic drive_sym(input logic d, input logic s, input bit push, input logic ed, input logic es);
      exp_t e;
      data_i  = d;
      valid_i = 1'b1;
      sync_i  = s;
      if (push) begin
         e.d = ed;
         e.s = es;
         q.push_back(e);
      end
      @(posedge clk);
   endtask

   task automatic idle_cycle();
      valid_i = 1'b0;
      data_i  = 1'($urandom_range(0, 1));
      sync_i  = 1'($urandom_range(0, 1));
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic send_block(input logic [N-1:0] src, input logic sync0,
                             input int gap_at, input int gap_len, input bit expect_err);
      for (int k = 0; k < N; k++) begin
         if (k == gap_at) begin
            for (int g = 0; g < gap_len; g++) idle_cycle();
         end
         drive_sym(il_bit(src, k), (k == 0) ? sync0 : 1'b0, have_prev,
                   have_prev ? prev_src[k] : 1'b0, (k == 0));
         if (k == 0 && expect_err) begin
            #1;
            chk("sync_err_pulse", sync_err_o, 1);
         end
         @(negedge clk);
      end
      prev_src  = src;
      have_prev = 1'b1;
   endtask

   task automatic send_partial(input logic [N-1:0] src, input int n);
      for (int k = 0; k < n; k++) begin
         drive_sym(il_bit(src, k), (k == 0), have_prev,
                   have_prev ? prev_src[k] : 1'b0, (k == 0));
         @(negedge clk);
      end
   endtask

   task automatic do_reset();
      chk("pending_before_reset", q.size(), 0);
      q.delete();
      rst     = 1'b0;
      valid_i = 1'b1;
      data_i  = 1'b1;
      sync_i  = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_data", data_o, 0);
      chk("rst_valid", valid_o, 0);
      chk("rst_sync", sync_o, 0);
      chk("rst_err", sync_err_o, 0);
      @(negedge clk);
      rst       = 1'b1;
      valid_i   = 1'b0;
      sync_i    = 1'b0;
      have_prev = 1'b0;
   endtask

   // Output monitor: pops one expectation per valid_o beat.
   always @(posedge clk) begin
      #1;
      if (!valid_o) vo_low_cnt++;
      if (sync_err_o) err_seen++;
      chk("sync_without_valid", sync_o & ~valid_o, 0);
      if (q.size() == 0) begin
         chk("unexpected_valid", valid_o, 0);
      end else if (valid_o) begin
         mon_e = q.pop_front();
         chk("data", data_o, mon_e.d);
         chk("sync", sync_o, mon_e.s);
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL timeout q=%0d", q.size());
      $fatal(1);
   end

   initial begin
      logic [N-1:0] src;
      logic [N-1:0] one_hot;
      int           err_before;

      rst       = 1'b0;
      valid_i   = 1'b0;
      data_i    = 1'b0;
      sync_i    = 1'b0;
      have_prev = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("init_data", data_o, 0);
      chk("init_valid", valid_o, 0);
      chk("init_sync", sync_o, 0);
      chk("init_err", sync_err_o, 0);
      @(negedge clk);
      rst = 1'b1;

      // Two blocks with sync at bits 0 and 16; nothing may come out of the first.
      src = N'($urandom);
      send_block(src, 1'b1, -1, 0, 1'b0);
      chk("fill_no_output", q.size(), 0);
      src = N'($urandom);
      send_block(src, 1'b1, -1, 0, 1'b0);
      chk("drain_first", q.size(), 0);

      // One-hot source blocks 0x0001..0x8000.
      for (int i = 0; i < N; i++) begin
         one_hot = N'(1) << i;
         send_block(one_hot, 1'b1, -1, 0, 1'b0);
      end
      chk("drain_onehot", q.size(), 0);

      // Three-cycle valid gap at k=7 in RUN.
      vo_low_cnt = 0;
      src = N'($urandom);
      send_block(src, 1'b1, 7, 3, 1'b0);
      chk("gap_valid_low", vo_low_cnt, 3);
      chk("drain_gap", q.size(), 0);

      // Misplaced sync at k=5 in RUN: restart, refill, then output resumes.
      err_before = err_seen;
      src = N'($urandom);
      send_partial(src, 5);
      have_prev = 1'b0;
      src = N'($urandom);
      send_block(src, 1'b1, -1, 0, 1'b1);
      chk("resync_no_output", q.size(), 0);
      src = N'($urandom);
      send_block(src, 1'b0, -1, 0, 1'b0);
      chk("resync_err_count", err_seen - err_before, 1);
      chk("drain_resync", q.size(), 0);

      // Reset at k=9 in RUN; unsynced input afterwards must be ignored.
      src = N'($urandom);
      send_partial(src, 9);
      do_reset();
      for (int i = 0; i < 20; i++) begin
         drive_sym(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, 1'b0);
         @(negedge clk);
      end
      src = N'($urandom);
      send_block(src, 1'b1, -1, 0, 1'b0);
      chk("post_reset_fill", q.size(), 0);
      src = N'($urandom);
      send_block(src, 1'b1, -1, 0, 1'b0);
      chk("drain_reset", q.size(), 0);

      // Random stream, 1000 blocks, sporadic gaps and optional sync at k=0.
      for (int b = 0; b < 1000; b++) begin
         src = N'($urandom);
         send_block(src, (b == 0) ? 1'b1 : 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, N - 1)) : -1,
                    int'($urandom_range(1, 3)), 1'b0);
      end
      chk("drain_random", q.size(), 0);

      idle_cycle();
      idle_cycle();
      chk("err_total", err_seen, 1);
      chk("final_queue", q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
